mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//   MEM stage of the 5-stage pipeline, directly downstream of the EX stage. Holds the
//   EX/MEM pipeline register, issues loads/stores to data memory over a req/ack handshake,
//   and stalls EX until the access completes. Presents a one-cycle MEM/WB result to writeback.
// PARAMETERS
//   TIMEOUT_CYCLES  255  cycles dmem_req may stay unacknowledged before the access aborts (1..1023)
// PORTS
//   clk            in   1   clock; all state updates on the rising edge
//   reset          in   1   asynchronous, active-high reset
//   ex_valid       in   1   EX presents an operation this cycle
//   ex_ready       out  1   MEM can accept; transfer when ex_valid && ex_ready
//   ex_alu_result  in   32  ALU result / effective address
//   ex_store_data  in   32  store data (rt value)
//   ex_write_reg   in   5   destination register
//   ex_mem_read    in   1   operation is a load
//   ex_mem_write   in   1   operation is a store
//   ex_reg_write   in   1   operation writes the register file
//   dmem_req       out  1   memory request, held until dmem_ack or timeout
//   dmem_we        out  1   1 = write, valid with dmem_req
//   dmem_addr      out  32  word address, stable while dmem_req
//   dmem_wdata     out  32  write data, stable while dmem_req
//   dmem_ack       in   1   memory completes the access this cycle
//   dmem_rdata     in   32  load data, valid in the dmem_ack cycle
//   wb_valid       out  1   one-cycle pulse: result for writeback
//   wb_data        out  32  load data or ALU result
//   wb_write_reg   out  5   destination register
//   wb_reg_write   out  1   register-file write enable
//   mem_err        out  1   with wb_valid: access aborted (timeout or misalign)
// BEHAVIOUR
//   - Reset: state IDLE; all outputs 0 except ex_ready=1. Reset mid-access drops dmem_req
//     immediately; an ack arriving later in IDLE is ignored.
//   - FSM IDLE -> REQ -> RESP -> IDLE. ex_ready=1 only in IDLE.
//   - IDLE, accepted ALU op (no mem_read/write): wb_valid next cycle, stay IDLE (1 op/cycle).
//   - IDLE, accepted mem op: EX/MEM fields captured; next state REQ.
//   - REQ: dmem_req=1, dmem_we=is_store, addr/wdata from captured op. Ack may arrive in
//     the first REQ cycle. On ack: latch dmem_rdata, -> RESP. Timeout counter zeroed on entry;
//     when it reaches TIMEOUT_CYCLES without ack: drop req, mem_err=1, -> RESP.
//   - RESP: wb_valid=1 for exactly one cycle, then IDLE. Minimum mem-op latency: 3 cycles.
//   - wb_data: load -> latched rdata; store/ALU -> alu_result.
//   - wb_reg_write = reg_write && !is_store && !mem_err (stores never write the register file).
//   - mem_read && mem_write both set: treated as load.
//   - ex_valid while ex_ready=0: EX must hold its inputs; MEM ignores them.
//   - wb_* registered; hold last values when wb_valid=0 (wb_reg_write forced 0).
// CONFIGURATION
//   MEM_ALIGN_CHECK_EN defined: mem op with alu_result[1:0]!=0 raises no dmem_req; goes
//     IDLE->REQ->RESP with mem_err=1, wb_reg_write=0.
//   Undefined: no check; dmem_addr carries the full 32-bit address, low bits included.
// STRUCTURE
//   pipeline_pkg: mem_state_t enum {IDLE,REQ,RESP}; ex_mem_t struct (alu_result, store_data,
//     write_reg, mem_read, mem_write, reg_write); WORD_W=32, REG_ADDR_W=5.
//   Sub-module mem_timeout_counter: clear/enable inputs, expired output, TIMEOUT_CYCLES param.
// TESTING
//   1 ALU op alu_result=0x0000_0010, write_reg=5, reg_write=1 -> next cycle wb_valid=1,
//     wb_data=0x10, wb_write_reg=5, wb_reg_write=1; back-to-back ALU ops accepted every cycle.
//   2 Load addr 0x100, ack 2 cycles after req with rdata 0xDEAD_BEEF -> dmem_we=0, addr=0x100
//     held, wb_data=0xDEADBEEF, wb_reg_write=1; ex_ready=0 throughout.
//   3 Store addr 0x200, data 0x1234 with ack in first REQ cycle -> dmem_we=1, wdata=0x1234,
//     wb_valid 1 cycle later with wb_reg_write=0, mem_err=0.
//   4 Load, never ack, TIMEOUT_CYCLES=4 -> req drops after 4 cycles, wb_valid with mem_err=1,
//     wb_reg_write=0, ex_ready=1 next cycle.
//   5 Reset asserted during REQ, then ack -> dmem_req=0 immediately, no wb_valid, ex_ready=1.
//   6 MEM_ALIGN_CHECK_EN, load addr 0x102 -> dmem_req never asserts, mem_err=1; macro off:
//     dmem_addr=0x102.

Source files
------------

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and widths for the MEM pipeline stage
package pipeline_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [WORD_W-1:0]     alu_result;
    logic [WORD_W-1:0]     store_data;
    logic [REG_ADDR_W-1:0] write_reg;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
  } ex_mem_t;

  // Any operation that touches data memory
  function automatic logic is_mem_op(input ex_mem_t op);
    return op.mem_read | op.mem_write;
  endfunction

  // A read+write combination behaves as a load, so only a pure write is a store
  function automatic logic is_store_op(input ex_mem_t op);
    return op.mem_write & ~op.mem_read;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EX->MEM, MEM->dmem and MEM->WB bus interfaces
interface ex_mem_if;
  import pipeline_pkg::*;

  logic                  ex_valid;
  logic                  ex_ready;
  logic [WORD_W-1:0]     ex_alu_result;
  logic [WORD_W-1:0]     ex_store_data;
  logic [REG_ADDR_W-1:0] ex_write_reg;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  ex_reg_write;

  modport master (
    output ex_valid, ex_alu_result, ex_store_data, ex_write_reg,
           ex_mem_read, ex_mem_write, ex_reg_write,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_alu_result, ex_store_data, ex_write_reg,
           ex_mem_read, ex_mem_write, ex_reg_write,
    output ex_ready
  );
endinterface

interface dmem_if;
  import pipeline_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [WORD_W-1:0] dmem_addr;
  logic [WORD_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [WORD_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

interface wb_if;
  import pipeline_pkg::*;

  logic                  wb_valid;
  logic [WORD_W-1:0]     wb_data;
  logic [REG_ADDR_W-1:0] wb_write_reg;
  logic                  wb_reg_write;
  logic                  mem_err;

  modport master (
    output wb_valid, wb_data, wb_write_reg, wb_reg_write, mem_err
  );

  modport slave (
    input  wb_valid, wb_data, wb_write_reg, wb_reg_write, mem_err
  );
endinterface

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - counts unacknowledged request cycles, flags expiry
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int                CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Expiry is seen during the TIMEOUT_CYCLES-th request cycle, so the
  // request is held for exactly TIMEOUT_CYCLES cycles before aborting.
  assign expired = (count == LAST);

  // Cycle counter: zeroed while idle, advances each request cycle, saturates at LAST
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage; optional MEM_ALIGN_CHECK_EN word-alignment abort
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  ex_mem_if.slave    ex,
  dmem_if.master     dmem,
  wb_if.master       wb
);

  mem_state_t state_q, state_d;
  ex_mem_t    ex_op;
  ex_mem_t    op_q;

  logic ready_c;
  logic req_c;
  logic we_c;
  logic cnt_clear;
  logic cnt_enable;
  logic cnt_expired;
  logic finish_c;
  logic finish_err_c;
  logic misaligned;
  logic accept;

  logic                  wb_valid_q;
  logic [WORD_W-1:0]     wb_data_q;
  logic [REG_ADDR_W-1:0] wb_write_reg_q;
  logic                  wb_reg_write_q;
  logic                  mem_err_q;

  assign ex_op.alu_result = ex.ex_alu_result;
  assign ex_op.store_data = ex.ex_store_data;
  assign ex_op.write_reg  = ex.ex_write_reg;
  assign ex_op.mem_read   = ex.ex_mem_read;
  assign ex_op.mem_write  = ex.ex_mem_write;
  assign ex_op.reg_write  = ex.ex_reg_write;

  assign accept = ex.ex_valid && ready_c;

`ifdef MEM_ALIGN_CHECK_EN
  // A misaligned access never reaches memory; it passes through REQ silently and aborts
  assign misaligned = (op_q.alu_result[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expired(cnt_expired)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, handshake and memory-request outputs
  always_comb begin
    state_d      = state_q;
    ready_c      = 1'b0;
    req_c        = 1'b0;
    we_c         = 1'b0;
    cnt_clear    = 1'b0;
    cnt_enable   = 1'b0;
    finish_c     = 1'b0;
    finish_err_c = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c   = 1'b1;
        cnt_clear = 1'b1;
        if (ex.ex_valid && is_mem_op(ex_op)) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (misaligned) begin
          finish_c     = 1'b1;
          finish_err_c = 1'b1;
          state_d      = RESP;
        end else begin
          req_c      = 1'b1;
          we_c       = is_store_op(op_q);
          cnt_enable = 1'b1;
          if (dmem.dmem_ack) begin
            finish_c = 1'b1;
            state_d  = RESP;
          end else if (cnt_expired) begin
            finish_c     = 1'b1;
            finish_err_c = 1'b1;
            state_d      = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // EX/MEM register: captured only for memory ops, held for the whole access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= '0;
    end else if (accept && is_mem_op(ex_op)) begin
      op_q <= ex_op;
    end
  end

  // MEM/WB register: one-cycle valid pulse, fields hold between pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_q     <= 1'b0;
      wb_data_q      <= '0;
      wb_write_reg_q <= '0;
      wb_reg_write_q <= 1'b0;
      mem_err_q      <= 1'b0;
    end else if (accept && !is_mem_op(ex_op)) begin
      wb_valid_q     <= 1'b1;
      wb_data_q      <= ex_op.alu_result;
      wb_write_reg_q <= ex_op.write_reg;
      wb_reg_write_q <= ex_op.reg_write;
      mem_err_q      <= 1'b0;
    end else if (finish_c) begin
      // An aborted load has no data; report the address instead
      wb_valid_q     <= 1'b1;
      wb_data_q      <= (op_q.mem_read && !finish_err_c) ? dmem.dmem_rdata : op_q.alu_result;
      wb_write_reg_q <= op_q.write_reg;
      wb_reg_write_q <= op_q.reg_write && !is_store_op(op_q) && !finish_err_c;
      mem_err_q      <= finish_err_c;
    end else begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      mem_err_q      <= 1'b0;
    end
  end

  assign ex.ex_ready      = ready_c;
  assign dmem.dmem_req    = req_c;
  assign dmem.dmem_we     = we_c;
  assign dmem.dmem_addr   = op_q.alu_result;
  assign dmem.dmem_wdata  = op_q.store_data;

  assign wb.wb_valid      = wb_valid_q;
  assign wb.wb_data       = wb_data_q;
  assign wb.wb_write_reg  = wb_write_reg_q;
  assign wb.wb_reg_write  = wb_reg_write_q;
  assign wb.mem_err       = mem_err_q;

endmodule
